// File: rtl/dm_dump_reader.sv
// Data-memory dump master: reads dm_ram from 0 to a latched last address and
// streams each word MSB byte first. Optional DM_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module dm_dump_reader #(
    parameter int ADDR_LENGTH = 11,
    parameter int DATA_LENGTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [ADDR_LENGTH-1:0] i_last_addr,
    output logic [ADDR_LENGTH-1:0] o_Addr,
    output logic                   o_Rd,
    output logic                   o_Wr,
    input  logic [DATA_LENGTH-1:0] i_MemData,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int NBYTES = (DATA_LENGTH + 7) / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int PW     = NBYTES * 8;

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, CKSUM, DONE} state_t;

    state_t                 state;
    logic [ADDR_LENGTH-1:0] last_addr;
    logic [DATA_LENGTH-1:0] word;
    logic [BW-1:0]          bidx;
`ifdef DM_DUMP_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    function automatic logic [PW-1:0] pad(input logic [DATA_LENGTH-1:0] d);
        pad = '0;
        pad[DATA_LENGTH-1:0] = d;
    endfunction

    function automatic logic [7:0] pick(input logic [PW-1:0] w, input logic [BW-1:0] i);
        pick = '0;
        for (int unsigned k = 0; k < NBYTES; k++)
            if (i == BW'(k)) pick = w[8*k +: 8];
    endfunction

    assign o_Wr = 1'b0;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            last_addr  <= '0;
            word       <= '0;
            bidx       <= '0;
            o_Addr     <= '0;
            o_Rd       <= 1'b0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef DM_DUMP_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        last_addr <= i_last_addr;
                        o_Addr    <= '0;
                        o_Rd      <= 1'b1;
                        o_busy    <= 1'b1;
                        state     <= READ;
`ifdef DM_DUMP_CHECKSUM_EN
                        csum      <= '0;
`endif
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    // First byte comes straight from the bus so SEND can present it immediately
                    word       <= i_MemData;
                    bidx       <= BW'(NBYTES - 1);
                    o_tx_data  <= pick(pad(i_MemData), BW'(NBYTES - 1));
                    o_Rd       <= 1'b0;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    if (o_tx_valid && i_tx_ready) begin
`ifdef DM_DUMP_CHECKSUM_EN
                        csum <= csum ^ o_tx_data;
`endif
                        if (bidx != '0) begin
                            bidx      <= bidx - 1'b1;
                            o_tx_data <= pick(pad(word), bidx - 1'b1);
                        end else if (o_Addr == last_addr) begin
`ifdef DM_DUMP_CHECKSUM_EN
                            o_tx_data <= csum ^ o_tx_data;
                            state     <= CKSUM;
`else
                            o_tx_valid <= 1'b0;
                            o_done     <= 1'b1;
                            state      <= DONE;
`endif
                        end else begin
                            o_tx_valid <= 1'b0;
                            o_Addr     <= o_Addr + 1'b1;
                            o_Rd       <= 1'b1;
                            state      <= READ;
                        end
                    end
                end
                CKSUM: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_dump_reader.sv
// Self-checking bench for dm_dump_reader: byte-queue model built from memory
// contents at each accepted start, checked every cycle on the falling edge.
module tb_dm_dump_reader;

    logic        clk = 1'b0;
    logic        reset, start, rd, wr, tx_valid, tx_ready, busy, done;
    logic [10:0] last_addr, addr;
    logic [15:0] mem_data;
    logic [7:0]  tx_data;
    logic [15:0] mem [0:2047];

    always #5 clk = ~clk;
    assign mem_data = mem[addr];

    dm_dump_reader #(.ADDR_LENGTH(11), .DATA_LENGTH(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_last_addr(last_addr),
        .o_Addr(addr), .o_Rd(rd), .o_Wr(wr), .i_MemData(mem_data),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_busy(busy), .o_done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ready driver: pattern entries are consumed only on cycles where a byte is offered
    bit rdy_pat[$];
    always @(posedge clk) begin
        #1;
        if (rdy_pat.size() == 0) tx_ready = 1'b1;
        else if (tx_valid) tx_ready = rdy_pat.pop_front();
        else tx_ready = 1'b0;
    end

    // behavioural model
    logic [7:0] byte_q[$];
    logic [7:0] logb[$];
    bit  exp_busy = 0, exp_done = 0, first_pend = 0, prev_stall = 0;
    int  rdcnt = 0, words = 0, cyc = 0;

    always @(negedge clk) begin
        bit done_n;
        check("wr_low", wr, 0);
        if (exp_busy) cyc++;
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        if (prev_stall) check("valid_held", tx_valid, 1);
        if (tx_valid) begin
            if (byte_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_byte: got %0h, expected no byte (t=%0t)", tx_data, $time);
            end else check("tx_data", tx_data, byte_q[0]);
            if (first_pend) begin
                check("first_valid_latency", cyc, 3);
                first_pend = 0;
            end
        end
        if (rd) begin
            check("rd_addr", addr, rdcnt / 2);
            rdcnt++;
        end
        if (done) check("rd_cycles", rdcnt, 2 * words);
        prev_stall = tx_valid && !tx_ready && !reset;

        if (reset) begin
            byte_q.delete();
            exp_busy = 0; exp_done = 0; first_pend = 0; prev_stall = 0;
        end else begin
            done_n = 0;
            if (!exp_busy && start) begin
                logic [7:0] x;
                x = 8'h00;
                words = int'(last_addr) + 1;
                for (int a = 0; a < words; a++) begin
                    byte_q.push_back(mem[a][15:8]);
                    byte_q.push_back(mem[a][7:0]);
                    x = x ^ mem[a][15:8] ^ mem[a][7:0];
                end
`ifdef DM_DUMP_CHECKSUM_EN
                byte_q.push_back(x);
`endif
                exp_busy = 1; rdcnt = 0; cyc = 0; first_pend = 1;
            end else if (exp_done) begin
                exp_busy = 0;
            end
            if (tx_valid && tx_ready && byte_q.size() > 0) begin
                logb.push_back(byte_q.pop_front());
                if (byte_q.size() == 0) done_n = 1;
            end
            exp_done = done_n;
        end
    end

    task automatic pulse_start(input logic [10:0] la);
        logb.delete();
        start = 1'b1; last_addr = la;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk); #1;
            if (done) seen = 1;
        end
        check({name, "_done_seen"}, seen, 1);
        @(posedge clk); #1;
    endtask

    task automatic expect_log(input string name, input logic [7:0] e[$]);
        check({name, "_count"}, logb.size(), e.size());
        for (int i = 0; i < e.size() && i < logb.size(); i++)
            check($sformatf("%s_byte%0d", name, i), logb[i], e[i]);
    endtask

    initial begin
        logic [7:0] e[$];
        reset = 1'b1; start = 1'b0; last_addr = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_addr", addr, 0);  check("rst_rd", rd, 0);
        check("rst_txd", tx_data, 0); check("rst_valid", tx_valid, 0);
        check("rst_busy", busy, 0);  check("rst_done", done, 0);
        @(posedge clk); #1;

        // three-word dump, ready always high
        mem[0] = 16'h1234; mem[1] = 16'h00AB; mem[2] = 16'hFFFF;
        pulse_start(11'd2);
        wait_done("s1", 100);
        e = {8'h12, 8'h34, 8'h00, 8'hAB, 8'hFF, 8'hFF};
`ifdef DM_DUMP_CHECKSUM_EN
        e.push_back(8'h8D);
`endif
        expect_log("s1", e);

        // single word
        mem[0] = 16'h0034;
        pulse_start(11'd0);
        wait_done("s2", 100);
        e = {8'h00, 8'h34};
`ifdef DM_DUMP_CHECKSUM_EN
        e.push_back(8'h34);
`endif
        expect_log("s2", e);

        // backpressure
        mem[0] = 16'hBEEF;
        rdy_pat = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pulse_start(11'd0);
        wait_done("s3", 100);
        e = {8'hBE, 8'hEF};
`ifdef DM_DUMP_CHECKSUM_EN
        e.push_back(8'h51);
`endif
        expect_log("s3", e);

        // reset after first byte of word 1
        mem[0] = 16'h1234;
        pulse_start(11'd2);
        begin
            bit got;
            got = 0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk); #1;
                if (logb.size() >= 3) got = 1;
            end
            check("s4_reach_word1", got, 1);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("s4_addr", addr, 0);  check("s4_rd", rd, 0);
        check("s4_txd", tx_data, 0); check("s4_valid", tx_valid, 0);
        check("s4_busy", busy, 0);  check("s4_done", done, 0);
        repeat (5) @(posedge clk);
        #1;
        pulse_start(11'd0);
        wait_done("s4r", 100);
        e = {8'h12, 8'h34};
`ifdef DM_DUMP_CHECKSUM_EN
        e.push_back(8'h26);
`endif
        expect_log("s4r", e);

        // start and last_addr changes while busy are ignored
        pulse_start(11'd2);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; last_addr = 11'd7;
        @(posedge clk); #1 start = 1'b0;
        wait_done("s5", 100);
        e = {8'h12, 8'h34, 8'h00, 8'hAB, 8'hFF, 8'hFF};
`ifdef DM_DUMP_CHECKSUM_EN
        e.push_back(8'h8D);
`endif
        expect_log("s5", e);

        // full address space: must terminate without wrapping
        for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 257) ^ 16'h5A3C;
        pulse_start(11'h7FF);
        wait_done("s6", 20000);
`ifdef DM_DUMP_CHECKSUM_EN
        check("s6_count", logb.size(), 4097);
`else
        check("s6_count", logb.size(), 4096);
`endif
        if (logb.size() >= 4096) begin
            check("s6_last_hi", logb[4094], 8'h5C);
            check("s6_last_lo", logb[4095], 8'hC3);
        end
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_dump_reader.md
Name: dm_dump_reader

Overview:
- Read-side master for the data memory: walks `dm_ram` from address 0 up to a programmed last address.
- Drives the memory Addr/Rd strobes, captures each returned word and serialises it MSB-byte-first over a valid/ready byte stream.
- The byte stream feeds the debug UART transmitter, so host software can dump data memory after a program halts.
- Never writes memory.

Parameters:
- ADDR_LENGTH, 11, width of memory address bus.
- DATA_LENGTH, 16, width of memory data word; NBYTES = (DATA_LENGTH+7)/8 bytes sent per word.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  single-cycle request to begin a dump
- i_last_addr  in  ADDR_LENGTH  last address to dump (inclusive), latched on accepted start
- o_Addr  out  ADDR_LENGTH  address to data memory
- o_Rd  out  1  read strobe to data memory
- o_Wr  out  1  write strobe to data memory, constant 0
- i_MemData  in  DATA_LENGTH  read data from data memory
- o_tx_data  out  8  byte to transmitter
- o_tx_valid  out  1  byte valid
- i_tx_ready  in  1  transmitter accepts byte
- o_busy  out  1  high from accepted start until return to IDLE
- o_done  out  1  one-cycle pulse when the dump completes

Behaviour:
- Reset (synchronous, i_reset high at an edge) clears all state:
  - State goes to IDLE.
  - o_Addr=0, o_Rd=0, o_Wr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
  - The latched last address and captured word clear to 0.
- Reset mid-dump aborts immediately; no further bytes or reads are issued.
- States: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE:
  - i_start=1 at an edge latches i_last_addr, sets addr=0 and goes to READ.
  - o_busy rises at the same edge.
- READ (1 cycle): o_Addr=addr, o_Rd=1; go to CAPTURE.
- CAPTURE (1 cycle):
  - o_Addr and o_Rd are held.
  - i_MemData is registered at the end of this cycle, so both combinational and 1-cycle-registered RAM reads are supported.
  - Set byte index b = NBYTES-1 and go to SEND.
- SEND:
  - o_Rd=0, o_tx_valid=1, o_tx_data = captured word bits [8b+7:8b]; bits above DATA_LENGTH read as 0.
  - A transfer happens on any edge with o_tx_valid & i_tx_ready.
  - o_tx_data must stay stable while valid is high and not yet accepted; valid never drops without a transfer.
  - On transfer with b>0: decrement b; the next byte is presented in the following cycle with valid still high, i.e. back-to-back transfers are allowed.
  - On transfer with b=0:
    - If addr == latched last address, go to DONE.
    - Otherwise addr = addr+1 and go to READ; o_tx_valid is low during READ/CAPTURE.
- DONE (1 cycle): o_done=1, then IDLE. o_busy drops at that edge.
- Timing:
  - First o_tx_valid is high in the 3rd cycle after the edge that accepted i_start.
  - Per-word overhead is 2 cycles plus NBYTES handshakes.
- i_start while busy is ignored.
- i_last_addr changes after start are ignored.
- Boundary cases:
  - i_last_addr=0 gives exactly one word.
  - i_last_addr = all ones dumps 2^ADDR_LENGTH words. The compare happens before the increment, so addr never wraps and the dump terminates.
- i_tx_ready held low stalls SEND indefinitely with outputs frozen.

Optional Feature:
- DM_DUMP_CHECKSUM_EN defined:
  - An 8-bit XOR of every transferred data byte is accumulated, cleared on accepted start and on reset.
  - After the last data byte, an extra state CKSUM presents the checksum byte with the same handshake; DONE follows its transfer.
- Undefined: no checksum byte, no accumulator logic; last data byte goes directly to DONE.

Test Plan:
- Memory preloaded with mem[0]=16'h1234, mem[1]=16'h00AB, mem[2]=16'hFFFF; i_last_addr=2, i_tx_ready=1 constant → bytes 12,34,00,AB,FF,FF in order; o_done pulses once; o_busy high throughout; o_Wr never 1.
- i_last_addr=0, mem[0]=16'h0034 → bytes 00,34 only; o_Rd high exactly 2 cycles at o_Addr=0.
- mem[0]=16'hBEEF, i_tx_ready toggling 0,0,1,0,1 → o_tx_data holds BE while unaccepted, then EF; no byte lost or repeated.
- i_reset pulsed after first byte of word 1 → next cycle all outputs 0, state IDLE; new i_start restarts cleanly from address 0.
- Second i_start pulse during dump and i_last_addr changed mid-dump → no effect on byte count or sequence.
- With DM_DUMP_CHECKSUM_EN, first scenario data → extra byte 12^34^00^AB^FF^FF = 8'h8D before o_done.
